// File: rtl/rom_arbiter_pkg.sv
// rtl/rom_arbiter_pkg.sv - shared FSM encoding, ROM window default and port-select codes
package rom_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic [11:0] ROM_BASE_DEFAULT = 12'h080;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

endpackage

// File: rtl/rom_arbiter_rr_pick2.sv
// rtl/rom_arbiter_rr_pick2.sv - two-way round-robin pick, favours the requester not last served
module rr_pick2
  import rom_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner
);

  always_comb begin
    winner = PORT_IF;
    if (req == 2'b11) begin
      winner = ~last;
    end else if (req[PORT_D]) begin
      winner = PORT_D;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - arbitrates fetch and data ports onto one ROM-Flash port, one access per 3 cycles
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter logic [11:0] ROM_BASE    = ROM_BASE_DEFAULT,
  parameter bit          WRITE_ALLOW = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] rom_addr,
  output logic        rom_we,
  output logic [31:0] rom_wdata,
  input  logic [31:0] rom_rdata
);

  state_t      state, state_nxt;
  logic        win_q, last_q, we_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] if_rdata_q, d_rdata_q;
  logic        if_err_q, d_err_q;
  logic        pick, legal, resp_err, any_req;
  logic [31:0] resp_data;

  rr_pick2 u_pick (
    .req    ({d_req, if_req}),
    .last   (last_q),
    .winner (pick)
  );

  assign any_req   = if_req | d_req;
  assign legal     = (addr_q[31:20] == ROM_BASE) && (!we_q || WRITE_ALLOW);
  assign resp_err  = !legal;
  assign resp_data = (legal && !we_q) ? rom_rdata : 32'h0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake and ROM outputs are decoded from state so reset clears them at once.
  always_comb begin
    state_nxt = state;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    rom_addr  = 32'h0;
    rom_we    = 1'b0;
    rom_wdata = 32'h0;
    if_rdata  = if_rdata_q;
    if_err    = if_err_q;
    d_rdata   = d_rdata_q;
    d_err     = d_err_q;
    case (state)
      ST_IDLE: begin
        if (any_req) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_nxt = ST_RESP;
        if_gnt    = (win_q == PORT_IF);
        d_gnt     = (win_q == PORT_D);
        if (legal) begin
          rom_addr  = addr_q;
          rom_we    = we_q;
          rom_wdata = wdata_q;
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
        if (win_q == PORT_IF) begin
          if_rvalid = 1'b1;
          if_rdata  = resp_data;
          if_err    = resp_err;
        end else begin
          d_rvalid = 1'b1;
          d_rdata  = resp_data;
          d_err    = resp_err;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      win_q      <= PORT_IF;
      last_q     <= PORT_D;
      we_q       <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      if_rdata_q <= 32'h0;
      if_err_q   <= 1'b0;
      d_rdata_q  <= 32'h0;
      d_err_q    <= 1'b0;
    end else begin
      if (state == ST_IDLE && any_req) begin
        win_q   <= pick;
        addr_q  <= (pick == PORT_D) ? d_addr : if_addr;
        we_q    <= (pick == PORT_D) && d_we;
        wdata_q <= (pick == PORT_D) ? d_wdata : 32'h0;
      end
      if (state == ST_ISSUE) last_q <= win_q;
      // Hold the response seen during RESP so rdata/err stay put between pulses.
      if (state == ST_RESP) begin
        if (win_q == PORT_IF) begin
          if_rdata_q <= resp_data;
          if_err_q   <= resp_err;
        end else begin
          d_rdata_q <= resp_data;
          d_err_q   <= resp_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - directed self-checking bench for rom_arbiter
module tb_rom_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;

  logic        if_gnt0, if_rvalid0, if_err0, d_gnt0, d_rvalid0, d_err0, rom_we0;
  logic [31:0] if_rdata0, d_rdata0, rom_addr0, rom_wdata0;
  logic [31:0] rom_rdata0 = 32'h0;
  logic        if_gnt1, if_rvalid1, if_err1, d_gnt1, d_rvalid1, d_err1, rom_we1;
  logic [31:0] if_rdata1, d_rdata1, rom_addr1, rom_wdata1;
  logic [31:0] rom_rdata1 = 32'h0;

  int   n_checks = 0;
  int   n_pass = 0;
  int   n_overlap = 0;
  int   n_rvalid = 0;
  logic saw_rom_we0 = 1'b0;
  logic saw_rom_addr0 = 1'b0;
  int   gi = 0;
  int   gcyc [4];
  logic gport [4];

  always #5 clock = ~clock;

  rom_arbiter #(.WRITE_ALLOW(1'b0)) dut0 (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt0), .if_rvalid(if_rvalid0),
    .if_rdata(if_rdata0), .if_err(if_err0),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt0),
    .d_rvalid(d_rvalid0), .d_rdata(d_rdata0), .d_err(d_err0),
    .rom_addr(rom_addr0), .rom_we(rom_we0), .rom_wdata(rom_wdata0), .rom_rdata(rom_rdata0)
  );

  rom_arbiter #(.WRITE_ALLOW(1'b1)) dut1 (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1), .if_rvalid(if_rvalid1),
    .if_rdata(if_rdata1), .if_err(if_err1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt1),
    .d_rvalid(d_rvalid1), .d_rdata(d_rdata1), .d_err(d_err1),
    .rom_addr(rom_addr1), .rom_we(rom_we1), .rom_wdata(rom_wdata1), .rom_rdata(rom_rdata1)
  );

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    if (a == 32'h0800_0010) return 32'hE7FE_2000;
    return a ^ 32'h5A5A_0000;
  endfunction

  // synchronous ROM: data valid the cycle after the address edge
  always @(posedge clock) begin
    rom_rdata0 <= rom_fn(rom_addr0);
    rom_rdata1 <= rom_fn(rom_addr1);
  end

  always @(negedge clock) begin
    if ($countones({if_gnt0, d_gnt0, if_rvalid0, d_rvalid0}) > 1) n_overlap++;
    if (rom_we0) saw_rom_we0 = 1'b1;
    if (rom_addr0 != 32'h0) saw_rom_addr0 = 1'b1;
    if (if_rvalid0 || d_rvalid0) n_rvalid++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  initial begin
    step();
    check("rst_handshake", {28'h0, if_gnt0, d_gnt0, if_rvalid0, d_rvalid0}, 32'h0);
    check("rst_rom", rom_addr0 | rom_wdata0 | {31'h0, rom_we0}, 32'h0);
    check("rst_rdata", if_rdata0 | d_rdata0, 32'h0);
    check("rst_err", {30'h0, if_err0, d_err0}, 32'h0);
    step();
    reset = 1'b0;
    step();

    // fetch read
    if_req = 1'b1; if_addr = 32'h0800_0010;
    step();
    check("if_gnt", {31'h0, if_gnt0}, 32'h1);
    check("if_no_dgnt", {31'h0, d_gnt0}, 32'h0);
    check("if_rom_addr", rom_addr0, 32'h0800_0010);
    if_req = 1'b0; if_addr = 32'h0;
    step();
    check("if_rvalid", {31'h0, if_rvalid0}, 32'h1);
    check("if_rdata", if_rdata0, 32'hE7FE_2000);
    check("if_err", {31'h0, if_err0}, 32'h0);
    check("if_rom_idle", rom_addr0, 32'h0);
    step();
    check("if_rvalid_pulse", {31'h0, if_rvalid0}, 32'h0);
    check("if_rdata_hold", if_rdata0, 32'hE7FE_2000);

    // legal data read
    d_req = 1'b1; d_addr = 32'h0800_0020;
    step();
    check("d_gnt", {31'h0, d_gnt0}, 32'h1);
    d_req = 1'b0;
    step();
    check("d_rvalid", {31'h0, d_rvalid0}, 32'h1);
    check("d_rdata", d_rdata0, 32'h525A_0020);
    check("d_err_legal", {31'h0, d_err0}, 32'h0);
    step();

    // out-of-range read
    saw_rom_addr0 = 1'b0;
    d_req = 1'b1; d_addr = 32'h2000_0000;
    step();
    check("oor_gnt", {31'h0, d_gnt0}, 32'h1);
    check("oor_rom_addr", rom_addr0, 32'h0);
    d_req = 1'b0;
    step();
    check("oor_rvalid", {31'h0, d_rvalid0}, 32'h1);
    check("oor_err", {31'h0, d_err0}, 32'h1);
    check("oor_rdata", d_rdata0, 32'h0);
    check("oor_rom_quiet", {31'h0, saw_rom_addr0}, 32'h0);
    step();

    // write gating: dut0 blocks writes, dut1 allows them
    saw_rom_we0 = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0800_0004; d_wdata = 32'h1234_5678;
    step();
    check("wr_blocked_we", {31'h0, rom_we0}, 32'h0);
    check("wr_allow_we", {31'h0, rom_we1}, 32'h1);
    check("wr_allow_addr", rom_addr1, 32'h0800_0004);
    check("wr_allow_wdata", rom_wdata1, 32'h1234_5678);
    d_req = 1'b0; d_we = 1'b0; d_wdata = 32'h0;
    step();
    check("wr_blocked_rvalid", {31'h0, d_rvalid0}, 32'h1);
    check("wr_blocked_err", {31'h0, d_err0}, 32'h1);
    check("wr_allow_err", {31'h0, d_err1}, 32'h0);
    check("wr_allow_rdata", d_rdata1, 32'h0);
    check("wr_allow_we_pulse", {31'h0, rom_we1}, 32'h0);
    check("wr_blocked_never_we", {31'h0, saw_rom_we0}, 32'h0);
    step();
    check("wr_err_hold", {31'h0, d_err0}, 32'h1);

    // tie from reset: IF, D, IF, D three cycles apart
    reset = 1'b1;
    if_req = 1'b1; d_req = 1'b1;
    if_addr = 32'h0800_0030; d_addr = 32'h0800_0040;
    step();
    step();
    reset = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (if_gnt0 || d_gnt0) begin
        if (gi < 4) begin
          gcyc[gi]  = c;
          gport[gi] = d_gnt0;
        end
        gi++;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    check("tie_count", gi, 32'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("tie_cycle%0d", k), gcyc[k], 1 + 3 * k);
      check($sformatf("tie_port%0d", k), {31'h0, gport[k]}, k % 2);
    end
    check("tie_if_rdata", if_rdata0, 32'h525A_0030);
    check("tie_d_rdata", d_rdata0, 32'h525A_0040);
    check("no_overlap", n_overlap, 32'd0);
    step();

    // reset mid-access after a fetch, so last-served is IF before reset
    if_req = 1'b1; if_addr = 32'h0800_0010;
    step();
    if_req = 1'b0;
    step();
    step();
    if_req = 1'b1;
    step();
    check("mid_pre_gnt", {31'h0, if_gnt0}, 32'h1);
    reset = 1'b1;
    #1;
    check("mid_gnt_clear", {31'h0, if_gnt0}, 32'h0);
    check("mid_rom_clear", rom_addr0, 32'h0);
    check("mid_rdata_clear", if_rdata0, 32'h0);
    if_req = 1'b0;
    n_rvalid = 0;
    step();
    step();
    if_req = 1'b1; d_req = 1'b1;
    reset = 1'b0;
    step();
    check("post_rst_if_wins", {31'h0, if_gnt0}, 32'h1);
    check("post_rst_d_waits", {31'h0, d_gnt0}, 32'h0);
    check("post_rst_no_rvalid", n_rvalid, 32'd0);
    if_req = 1'b0; d_req = 1'b0;
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 SHALL have parameter ROM_BASE, default 12'h080, address bits [31:20] that select the ROM-Flash window 0x0800_0000-0x080F_FFFF.
REQ-002 SHALL have parameter WRITE_ALLOW, default 0, where 1 permits data-port writes into ROM-Flash (programming mode).
REQ-003 SHALL have ports, one per line, as follows.
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  instruction-fetch read request.
- if_addr  in  32  fetch address.
- if_gnt  out  1  fetch request accepted (1-cycle pulse).
- if_rvalid  out  1  fetch response valid (1-cycle pulse).
- if_rdata  out  32  fetch read data.
- if_err  out  1  fetch error, qualified by if_rvalid.
- d_req  in  1  data-port request.
- d_we  in  1  data-port write (1) / read (0).
- d_addr  in  32  data-port address.
- d_wdata  in  32  data-port write data.
- d_gnt  out  1  data request accepted (1-cycle pulse).
- d_rvalid  out  1  data response valid (1-cycle pulse).
- d_rdata  out  32  data read data.
- d_err  out  1  data error, qualified by d_rvalid.
- rom_addr  out  32  address to ROM-Flash.
- rom_we  out  1  write enable to ROM-Flash.
- rom_wdata  out  32  write data to ROM-Flash.
- rom_rdata  in  32  read data from ROM-Flash, valid one cycle after the issue edge.

Function
REQ-004 SHALL implement FSM IDLE -> ISSUE -> RESP -> IDLE, exactly one cycle per state.
REQ-005 IDLE: no request -> stay in IDLE; any request -> latch winner, addr, we and wdata, then go to ISSUE.
REQ-006 Arbitration SHALL be round-robin via a last-served bit; on a tie the requester not last served wins; the loser's request is unaffected.
REQ-007 ISSUE SHALL assert the winner's gnt for exactly one cycle and drive rom_addr, rom_we and rom_wdata from the latched values.
REQ-008 An access SHALL be legal iff addr[31:20]==ROM_BASE and, for writes, WRITE_ALLOW==1.
REQ-009 An illegal access SHALL drive rom_addr=0, rom_we=0 and rom_wdata=0 in ISSUE (no ROM access), then set err=1 in RESP.
REQ-010 Fetch requests SHALL always be reads; the fetch port has no write path.
REQ-011 RESP SHALL pulse the winner's rvalid for one cycle, with rdata=rom_rdata sampled at that edge for a legal read, and rdata=0 for writes and errors.
REQ-012 Latency SHALL be: req sampled in IDLE at edge N -> gnt high in cycle N+1 -> rvalid high in cycle N+2; throughput one access per 3 cycles.
REQ-013 Outside ISSUE, rom_addr, rom_we and rom_wdata SHALL be 0 (outside the ROM window, so the ROM is idle).
REQ-014 rdata and err SHALL hold their last value between rvalid pulses; gnt and rvalid of both ports are never high together.
REQ-015 A requester SHALL hold req, addr, we and wdata stable until its gnt; the request is consumed at the edge following gnt.
REQ-016 A req held high after gnt SHALL count as a new request at the next IDLE.
REQ-017 The last-served bit SHALL update in ISSUE to the current winner.

Reset
REQ-018 On reset, outputs SHALL be: state=IDLE; all gnt, rvalid, err and rom_we = 0; all rdata, rom_addr and rom_wdata = 0; last-served=data, so fetch wins the first tie.
REQ-019 Reset asserted in ISSUE or RESP SHALL abort the access with no rvalid afterwards; a ROM write already issued at that edge is not rolled back.

Structure
REQ-020 A shared package SHALL hold the FSM state encoding, the ROM_BASE default, and the port-select encoding (PORT_IF=0, PORT_D=1).
REQ-021 The round-robin pick SHALL be one sub-module, rr_pick2 (inputs: req[1:0], last; output: winner), purely combinational; all sequencing stays in rom_arbiter.

Verification
REQ-022 Fetch read: if_req with if_addr=0x0800_0010 and the ROM model returning 0xE7FE_2000 -> if_gnt in cycle N+1, if_rvalid in cycle N+2, if_rdata=0xE7FE_2000, if_err=0.
REQ-023 Tie: both requests held from reset -> grants in the order IF, D, IF, D with gnt pulses 3 cycles apart, and no overlap of any gnt or rvalid.
REQ-024 Out-of-range: d_addr=0x2000_0000 read -> rom_addr stays 0 throughout, d_rvalid=1 with d_err=1 and d_rdata=0.
REQ-025 Write gating: d_we=1, d_addr=0x0800_0004, d_wdata=0x1234_5678 with WRITE_ALLOW=0 -> rom_we never high and d_err=1; with WRITE_ALLOW=1 -> rom_we=1 for one cycle with matching rom_addr and rom_wdata, and d_err=0.
REQ-026 Reset mid-access: assert reset during ISSUE -> all outputs 0 immediately, no rvalid pulse afterwards, and the first tie after release is won by fetch.
